// File: rtl/multiword_add_seq_if.sv
// Request/result bus of the sequential multi-word adder.
// The sub signal exists only when MULTIWORD_ADD_SEQ_SUB_EN is defined.
interface multiword_add_seq_if #(
    parameter int SLICES = 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [16*SLICES-1:0]  A;
    logic [16*SLICES-1:0]  B;
    logic                  cin;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    logic                  sub;
`endif
    logic                  out_valid;
    logic                  out_ready;
    logic [16*SLICES-1:0]  S;
    logic                  C;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    // Block side: accepts requests, produces results.
    modport slave (
        input  in_valid, A, B, cin, sub, out_ready,
        output in_ready, out_valid, S, C
    );
    // Requester/consumer side.
    modport master (
        output in_valid, A, B, cin, sub, out_ready,
        input  in_ready, out_valid, S, C
    );
`else
    // Block side: accepts requests, produces results.
    modport slave (
        input  in_valid, A, B, cin, out_ready,
        output in_ready, out_valid, S, C
    );
    // Requester/consumer side.
    modport master (
        output in_valid, A, B, cin, out_ready,
        input  in_ready, out_valid, S, C
    );
`endif
endinterface

// File: rtl/multiword_add_seq.sv
// Sequential multi-word adder: adds two 16*SLICES-bit operands one 16-bit
// slice per cycle through a shared external 16-bit adder, LSB slice first.
// Optional subtract mode (A-B via A + ~B + 1) is enabled by defining
// MULTIWORD_ADD_SEQ_SUB_EN. SLICES must be in 2..8.
module multiword_add_seq #(
    parameter int SLICES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    multiword_add_seq_if.slave  io,
    output logic [15:0]         add_a,
    output logic [15:0]         add_b,
    output logic                add_cin,
    input  logic [15:0]         add_s,
    input  logic                add_c,
    output logic                busy
);
    localparam int IW = $clog2(SLICES);
    localparam logic [IW-1:0] LAST = IW'(SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                   state_q;
    logic [IW-1:0]            idx_q;
    logic                     carry_q;
    logic [SLICES-1:0][15:0]  a_q;
    logic [SLICES-1:0][15:0]  b_q;
    logic [SLICES-1:0][15:0]  s_q;
    logic [SLICES-1:0][15:0]  s_d;
    logic                     c_q;
    logic                     in_ready_q;
    logic                     out_valid_q;
    logic                     busy_q;
    logic                     cin_eff;
    logic                     sub_eff;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    logic                     sub_q;
    // Subtraction starts with carry 1 to complete the two's complement of B.
    assign cin_eff = io.sub ? 1'b1 : io.cin;
    assign sub_eff = sub_q;
`else
    assign cin_eff = io.cin;
    assign sub_eff = 1'b0;
`endif

    // Shared adder operands are only driven while a slice is being processed.
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state_q == RUN) begin
            add_a   = a_q[idx_q];
            add_b   = sub_eff ? ~b_q[idx_q] : b_q[idx_q];
            add_cin = carry_q;
        end
    end

    // Result image with the current slice's sum merged in.
    always_comb begin
        s_d = s_q;
        if (state_q == RUN)
            s_d[idx_q] = add_s;
    end

    // Control FSM with registered handshake outputs; operands are latched at
    // acceptance so later changes on the bus cannot corrupt the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            s_q         <= '0;
            c_q         <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (io.in_valid) begin
                        a_q        <= io.A;
                        b_q        <= io.B;
                        carry_q    <= cin_eff;
                        idx_q      <= '0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
                        sub_q      <= io.sub;
`endif
                        state_q    <= RUN;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    s_q     <= s_d;
                    carry_q <= add_c;
                    idx_q   <= idx_q + IW'(1);
                    if (idx_q == LAST) begin
                        c_q         <= add_c;
                        idx_q       <= '0;
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    idx_q       <= '0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign io.in_ready  = in_ready_q;
    assign io.out_valid = out_valid_q;
    assign io.S         = s_q;
    assign io.C         = c_q;
    assign busy         = busy_q;

endmodule
